// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: accepts one request, drives the FPU (single-cycle or
// multi-cycle divide with busy timeout) and returns one tagged response.
module fpu_issue_ctrl #(
    parameter int unsigned DIV_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [3:0]  req_tag,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic [3:0]  resp_tag,
    output logic [3:0]  fpu_op,
    output logic [63:0] fpu_a,
    output logic [63:0] fpu_b,
    input  logic        fpu_busy,
    input  logic [63:0] fpu_res
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EXEC    = 3'd1;
    localparam logic [2:0] S_DLAUNCH = 3'd2;
    localparam logic [2:0] S_DWAIT   = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [3:0]  OP_NOP = 4'b0000;
    localparam logic [3:0]  OP_DIV = 4'b0011;
    localparam logic [15:0] TMO    = 16'(DIV_TIMEOUT);

    logic [2:0]  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [3:0]  tag_q, tag_d;
    logic [15:0] cnt_q, cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic        rerr_q, rerr_d;
    logic [3:0]  rtag_q, rtag_d;
    logic        op_single;
    logic [15:0] cnt_inc;

    assign op_single = op_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                    4'b0101, 4'b0110, 4'b1001, 4'b1010,
                                    4'b1011, 4'b1100, 4'b1101};
    assign cnt_inc   = cnt_q + 16'd1;

    // Reset gates req_ready so every output reads zero while reset is held.
    assign req_ready  = (state_q == S_IDLE) && reset;
    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = rdata_q;
    assign resp_err   = rerr_q;
    assign resp_tag   = rtag_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        rtag_d  = rtag_q;
        fpu_op  = OP_NOP;
        fpu_a   = '0;
        fpu_b   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    tag_d   = req_tag;
                    state_d = (req_op == OP_DIV) ? S_DLAUNCH : S_EXEC;
                end
            end
            S_EXEC: begin
                rtag_d  = tag_q;
                state_d = S_RESP;
                if (op_single) begin
                    fpu_op  = op_q;
                    fpu_a   = a_q;
                    fpu_b   = b_q;
                    rdata_d = fpu_res;
                    rerr_d  = 1'b0;
                end else begin
                    rdata_d = '0;
                    rerr_d  = 1'b1;
                end
            end
            S_DLAUNCH: begin
                fpu_op = OP_DIV;
                fpu_a  = a_q;
                fpu_b  = b_q;
                // A busy divider (stale or relaunched) delays the launch.
                if (!fpu_busy) begin
                    cnt_d   = '0;
                    state_d = S_DWAIT;
                end
            end
            S_DWAIT: begin
                fpu_op = OP_DIV;
                fpu_a  = a_q;
                fpu_b  = b_q;
                rtag_d = tag_q;
                if (!fpu_busy) begin
                    rdata_d = fpu_res;
                    rerr_d  = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= TMO) begin
                        rdata_d = '0;
                        rerr_d  = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
            rtag_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
            rtag_q  <= rtag_d;
        end
    end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter DIV_TIMEOUT, default 255: maximum fpu_busy-high cycles tolerated per divide (1..65535).
REQ-002 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req_valid  input  1; req_ready  output  1; req_op  input  4 (FPU opcode); req_a, req_b  input  64 each (signed Q-format operands); req_tag  input  4.
REQ-005 SHALL have ports: resp_valid  output  1; resp_ready  input  1; resp_data  output  64; resp_err  output  1; resp_tag  output  4.
REQ-006 SHALL have FPU-side ports: fpu_op  output  4; fpu_a, fpu_b  output  64 each; fpu_busy  input  1; fpu_res  input  64 (combinational result of the driven op).

Function
REQ-007 SHALL implement states IDLE, EXEC, DIV_LAUNCH, DIV_WAIT, RESP.
REQ-008 SHALL assert req_ready only in IDLE; a request is accepted on a cycle with req_valid && req_ready, registering op, a, b, tag.
REQ-009 SHALL classify opcodes 0000,0001,0010,0100,0101,0110,1001,1010,1011,1100,1101 as single-cycle, 0011 as divide, all others as illegal.
REQ-010 SHALL, on acceptance, go IDLE->EXEC for single-cycle and illegal ops, IDLE->DIV_LAUNCH for divide.
REQ-011 SHALL, in EXEC, drive registered op/a/b to the FPU and capture fpu_res into resp_data at cycle end with resp_err=0, then go to RESP (accept at N -> resp_valid at N+2).
REQ-012 SHALL, for illegal ops in EXEC, drive fpu_op=0000 with zero operands, set resp_data=0 and resp_err=1, then go to RESP.
REQ-013 SHALL, in DIV_LAUNCH, drive fpu_op=0011 with registered operands; stay while fpu_busy=1; when fpu_busy=0 (launch occurs that cycle) go to DIV_WAIT and clear the timeout counter.
REQ-014 SHALL, in DIV_WAIT, hold fpu_op=0011 and operands; while fpu_busy=1 increment a 16-bit counter; on first fpu_busy=0 capture fpu_res, resp_err=0, go to RESP.
REQ-015 SHALL, if the counter reaches DIV_TIMEOUT with fpu_busy still 1, set resp_data=0, resp_err=1, go to RESP.
REQ-016 SHALL tolerate the divider relaunch that occurs on the completion cycle; the next divide waits in DIV_LAUNCH until fpu_busy=0 (REQ-013).
REQ-017 SHALL, in RESP, assert resp_valid with stable resp_data/resp_err/resp_tag until resp_valid && resp_ready, then go to IDLE; no new request is accepted on that cycle.
REQ-018 SHALL drive fpu_op=0000, fpu_a=fpu_b=0 in IDLE and RESP.
REQ-019 SHALL pass data and tag unmodified; no arithmetic is performed in this block.
REQ-020 SHALL ignore req_valid in all states except IDLE; req inputs need not be held after acceptance.

Reset
REQ-021 SHALL, on reset low, immediately enter IDLE and clear resp_valid, resp_err, resp_data, resp_tag, counter and registered operands; req_ready=1 after release.
REQ-022 SHALL, on reset mid-divide, abandon the operation without emitting a response; a stale divider busy is absorbed by DIV_LAUNCH.
REQ-023 SHALL produce outputs of 0 (fpu_op=0000) throughout reset assertion.

Verification
REQ-024 Add: op=0000, a=0x0000_0000_0001_8000, b=0x0000_0000_0000_8000, tag=3 accepted at N -> resp_valid at N+2, resp_data equals model fpu_res for the driven op/operands, resp_err=0, resp_tag=3.
REQ-025 Divide: op=0011, divider model busy for 20 cycles after launch -> fpu_op=0011 held 22 cycles total, resp_valid one cycle after busy falls, resp_data = model quotient.
REQ-026 Back-to-back divide with model relaunching on the completion cycle -> second request waits in DIV_LAUNCH until busy=0, both results correct, tags in order.
REQ-027 Timeout: DIV_TIMEOUT=8, busy stuck high -> resp_valid after 8 counted cycles, resp_data=0, resp_err=1.
REQ-028 Illegal op=0111 and resp_ready held low 5 cycles -> resp_err=1, resp_data=0, outputs stable while stalled, req_ready=0 until handshake.
REQ-029 Reset asserted during DIV_WAIT -> all outputs 0 asynchronously, no response after release, next add completes at N+2.
